// File: rtl/vsync_std_detector.sv
// PAL/NTSC standard detector: filters VSYNC, measures the period between falling edges
// and locks onto a standard after CONFIRM_COUNT consecutive agreeing frames.
module vsync_std_detector #(
   parameter int CLK_FREQ              = 250_000,
   parameter int NTSC_PAL_THRESHOLD_MS = 18,
   parameter int PERIOD_MIN_MS         = 10,
   parameter int PERIOD_MAX_MS         = 30,
   parameter int TIMEOUT_MS            = 40,
   parameter int CONFIRM_COUNT         = 4,
   parameter int GLITCH_CYCLES         = 2,
   parameter int CNT_W                 = $clog2(TIMEOUT_MS * (CLK_FREQ / 1000) + 1)
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             vsync_in,
   input  logic             csync_in,
   output logic             csync_out,
   output logic [2:0]       format_out,
   output logic             format_valid_out,
   output logic             format_change_out,
   output logic [CNT_W-1:0] period_out,
   output logic             period_strobe_out
);

   localparam int MS = CLK_FREQ / 1000;
   localparam int GW = $clog2(GLITCH_CYCLES + 1);
   localparam int AW = $clog2(CONFIRM_COUNT + 1);

   localparam logic [CNT_W-1:0] T_MAX  = CNT_W'(TIMEOUT_MS * MS);
   localparam logic [CNT_W-1:0] P_MIN  = CNT_W'(PERIOD_MIN_MS * MS);
   localparam logic [CNT_W-1:0] P_MAX  = CNT_W'(PERIOD_MAX_MS * MS);
   localparam logic [CNT_W-1:0] P_THR  = CNT_W'(NTSC_PAL_THRESHOLD_MS * MS);
   localparam logic [GW-1:0]    G_LAST = GW'(GLITCH_CYCLES - 1);
   localparam logic [AW-1:0]    A_MAX  = AW'(CONFIRM_COUNT);

   localparam logic [2:0] FMT_UNK  = 3'b000;
   localparam logic [2:0] FMT_NTSC = 3'b010;
   localparam logic [2:0] FMT_PAL  = 3'b100;

   typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_LOCKED} state_t;

   logic             sync1_q, sync1_d, sync2_q, sync2_d;
   logic             filt_q, filt_d;
   logic [GW-1:0]    gcnt_q, gcnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_t           state_q, state_d;
   logic [AW-1:0]    agree_q, agree_d;
   logic [2:0]       prev_q, prev_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             strobe_q, strobe_d;
   logic [2:0]       format_q, format_d;
   logic             valid_q, valid_d;
   logic             change_q, change_d;
   logic             csync_q, csync_d;
   logic             ev;
   logic [2:0]       cand;

   function automatic logic [2:0] classify(input logic [CNT_W-1:0] p);
      if (p < P_MIN || p > P_MAX) return FMT_UNK;
      else if (p > P_THR)         return FMT_PAL;
      else                        return FMT_NTSC;
   endfunction

   always_comb begin
      sync1_d  = vsync_in;
      sync2_d  = sync1_q;
      filt_d   = filt_q;
      gcnt_d   = '0;
      cnt_d    = cnt_q;
      state_d  = state_q;
      agree_d  = agree_q;
      prev_d   = prev_q;
      period_d = period_q;
      strobe_d = 1'b0;
      format_d = format_q;
      valid_d  = valid_q;
      change_d = 1'b0;
      csync_d  = csync_in;
      cand     = classify(period_q);

      // The filtered level follows the synchronised one only after it has differed long enough
      if (sync2_q != filt_q) begin
         if (gcnt_q == G_LAST) filt_d = sync2_q;
         else                  gcnt_d = gcnt_q + 1'b1;
      end
      ev = filt_q & ~filt_d;

      if (ev)                  cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      else if (cnt_q != T_MAX) cnt_d = cnt_q + 1'b1;

      if (state_q == S_IDLE) begin
         if (ev) state_d = S_MEASURE;
      end else begin
         if (ev) begin
            period_d = cnt_q;
            strobe_d = 1'b1;
         end else if (cnt_q == T_MAX) begin
            state_d  = S_IDLE;
            format_d = FMT_UNK;
            valid_d  = 1'b0;
            agree_d  = '0;
            prev_d   = FMT_UNK;
            change_d = (state_q == S_LOCKED);
         end

         // Classification runs on the registered period, one cycle behind the strobe
         if (strobe_q) begin
            if (cand == FMT_UNK)     agree_d = '0;
            else if (cand == prev_q) agree_d = (agree_q == A_MAX) ? agree_q : agree_q + 1'b1;
            else                     agree_d = {{(AW-1){1'b0}}, 1'b1};
            prev_d = cand;
            if (cand != FMT_UNK && agree_d == A_MAX && cand != format_q) begin
               format_d = cand;
               valid_d  = 1'b1;
               change_d = 1'b1;
               state_d  = S_LOCKED;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         filt_q   <= 1'b1;
         gcnt_q   <= '0;
         cnt_q    <= '0;
         state_q  <= S_IDLE;
         agree_q  <= '0;
         prev_q   <= FMT_UNK;
         period_q <= '0;
         strobe_q <= 1'b0;
         format_q <= FMT_UNK;
         valid_q  <= 1'b0;
         change_q <= 1'b0;
         csync_q  <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         filt_q   <= filt_d;
         gcnt_q   <= gcnt_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         agree_q  <= agree_d;
         prev_q   <= prev_d;
         period_q <= period_d;
         strobe_q <= strobe_d;
         format_q <= format_d;
         valid_q  <= valid_d;
         change_q <= change_d;
         csync_q  <= csync_d;
      end
   end

   assign csync_out         = csync_q;
   assign format_out        = format_q;
   assign format_valid_out  = valid_q;
   assign format_change_out = change_q;
   assign period_out        = period_q;
   assign period_strobe_out = strobe_q;

endmodule

// File: tb/tb_vsync_std_detector.sv
// Bench for vsync_std_detector, run with CLK_FREQ=50_000 (MS=50 cycles) so the
// whole sequence of frames, timeout and reset stays short.
module tb_vsync_std_detector;

   localparam int CLK_FREQ = 50_000;
   localparam int MS       = 50;
   localparam int CNT_W    = $clog2(40 * MS + 1);
   localparam int TMO      = 40 * MS;
   localparam int LOW      = 20;
   localparam int NROWS    = 23;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             vsync = 1'b1;
   logic             csync = 1'b0;
   logic             csync_out;
   logic [2:0]       format_out;
   logic             format_valid_out;
   logic             format_change_out;
   logic [CNT_W-1:0] period_out;
   logic             period_strobe_out;

   vsync_std_detector #(.CLK_FREQ(CLK_FREQ)) dut (
      .clk_in            (clk),
      .rst_n_in          (rst_n),
      .vsync_in          (vsync),
      .csync_in          (csync),
      .csync_out         (csync_out),
      .format_out        (format_out),
      .format_valid_out  (format_valid_out),
      .format_change_out (format_change_out),
      .period_out        (period_out),
      .period_strobe_out (period_strobe_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int   cyc = 0, strobe_cnt = 0, change_cnt = 0;
   int   last_strobe_cyc = 0, valid_fall_cyc = 0;
   int   consec_err = 0, csync_err = 0;
   logic prev_strobe = 1'b0, prev_change = 1'b0, prev_valid = 1'b0;
   logic exp_csync;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) exp_csync <= 1'b0;
      else        exp_csync <= csync;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (period_strobe_out) begin
         strobe_cnt      = strobe_cnt + 1;
         last_strobe_cyc = cyc;
      end
      if (format_change_out) change_cnt = change_cnt + 1;
      if ((period_strobe_out && prev_strobe) || (format_change_out && prev_change))
         consec_err = consec_err + 1;
      if (prev_valid && !format_valid_out) valid_fall_cyc = cyc;
      if (csync_out !== exp_csync) csync_err = csync_err + 1;
      prev_strobe = period_strobe_out;
      prev_change = format_change_out;
      prev_valid  = format_valid_out;
   end

   initial begin
      forever begin
         @(negedge clk);
         csync = 1'($urandom_range(0, 1));
      end
   end

   typedef struct {
      int         period;
      int         n;
      bit         glitch;
      logic [2:0] fmt;
      logic       vld;
      int         strobes;
      int         changes;
      int         per;
   } row_t;

   row_t rows [NROWS];

   task automatic check(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One frame: high for P-LOW cycles, then the falling edge and LOW cycles low
   task automatic send_frame(input int p, input bit g);
      int hi = p - LOW;
      vsync = 1'b1;
      if (g) begin
         repeat (hi / 2) @(negedge clk);
         vsync = 1'b0;
         @(negedge clk);
         vsync = 1'b1;
         repeat (hi - hi / 2 - 1) @(negedge clk);
      end else begin
         repeat (hi) @(negedge clk);
      end
      vsync = 1'b0;
      if (g) begin
         repeat (10) @(negedge clk);
         vsync = 1'b1;
         @(negedge clk);
         vsync = 1'b0;
         repeat (LOW - 11) @(negedge clk);
      end else begin
         repeat (LOW) @(negedge clk);
      end
   endtask

   task automatic run_row(input int i);
      strobe_cnt = 0;
      change_cnt = 0;
      for (int k = 0; k < rows[i].n; k++) send_frame(rows[i].period, rows[i].glitch);
      check($sformatf("row%0d_format", i),  int'(format_out),       int'(rows[i].fmt));
      check($sformatf("row%0d_valid", i),   int'(format_valid_out), int'(rows[i].vld));
      check($sformatf("row%0d_strobes", i), strobe_cnt,             rows[i].strobes);
      check($sformatf("row%0d_changes", i), change_cnt,             rows[i].changes);
      check($sformatf("row%0d_period", i),  int'(period_out),       rows[i].per);
   endtask

   initial begin
      //            period  n  glitch fmt     vld   strobes changes period_out
      rows[0]  = '{1000, 2, 1'b0, 3'b000, 1'b0, 1, 0, 1000};
      rows[1]  = '{1000, 2, 1'b0, 3'b000, 1'b0, 2, 0, 1000};
      rows[2]  = '{1000, 1, 1'b0, 3'b100, 1'b1, 1, 1, 1000};
      rows[3]  = '{ 834, 3, 1'b0, 3'b100, 1'b1, 3, 0,  834};
      rows[4]  = '{ 834, 1, 1'b0, 3'b010, 1'b1, 1, 1,  834};
      rows[5]  = '{ 900, 4, 1'b0, 3'b010, 1'b1, 4, 0,  900};
      rows[6]  = '{ 901, 3, 1'b0, 3'b010, 1'b1, 3, 0,  901};
      rows[7]  = '{ 901, 1, 1'b0, 3'b100, 1'b1, 1, 1,  901};
      rows[8]  = '{ 834, 2, 1'b0, 3'b100, 1'b1, 2, 0,  834};
      rows[9]  = '{ 499, 1, 1'b0, 3'b100, 1'b1, 1, 0,  499};
      rows[10] = '{ 834, 3, 1'b0, 3'b100, 1'b1, 3, 0,  834};
      rows[11] = '{ 834, 1, 1'b0, 3'b010, 1'b1, 1, 1,  834};
      rows[12] = '{1500, 3, 1'b0, 3'b010, 1'b1, 3, 0, 1500};
      rows[13] = '{1500, 1, 1'b0, 3'b100, 1'b1, 1, 1, 1500};
      rows[14] = '{1501, 1, 1'b0, 3'b100, 1'b1, 1, 0, 1501};
      rows[15] = '{1000, 2, 1'b1, 3'b100, 1'b1, 2, 0, 1000};
      rows[16] = '{ 500, 4, 1'b0, 3'b010, 1'b1, 4, 1,  500};
      // after timeout: first edge is a fresh reference, period_out keeps its last value
      rows[17] = '{1000, 1, 1'b0, 3'b000, 1'b0, 0, 0,  500};
      rows[18] = '{1000, 3, 1'b0, 3'b000, 1'b0, 3, 0, 1000};
      rows[19] = '{1000, 1, 1'b0, 3'b100, 1'b1, 1, 1, 1000};
      // after asynchronous reset
      rows[20] = '{1000, 2, 1'b0, 3'b000, 1'b0, 1, 0, 1000};
      rows[21] = '{1000, 2, 1'b0, 3'b000, 1'b0, 2, 0, 1000};
      rows[22] = '{1000, 1, 1'b0, 3'b100, 1'b1, 1, 1, 1000};

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_format", int'(format_out), 0);
      check("reset_valid", int'(format_valid_out), 0);
      check("reset_period", int'(period_out), 0);
      check("reset_strobe", int'(period_strobe_out), 0);
      check("reset_csync", int'(csync_out), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i <= 16; i++) run_row(i);

      // Loss of VSYNC while locked
      vsync      = 1'b1;
      change_cnt = 0;
      begin
         int w = 0;
         while (format_valid_out && w < 3 * TMO) begin
            @(negedge clk);
            w++;
         end
      end
      repeat (3) @(negedge clk);
      check("timeout_valid", int'(format_valid_out), 0);
      check("timeout_format", int'(format_out), 0);
      check("timeout_delay", valid_fall_cyc - last_strobe_cyc, TMO);
      check("timeout_changes", change_cnt, 1);

      for (int i = 17; i <= 19; i++) run_row(i);

      // Asynchronous reset between clock edges while locked
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("areset_format", int'(format_out), 0);
      check("areset_valid", int'(format_valid_out), 0);
      check("areset_change", int'(format_change_out), 0);
      check("areset_period", int'(period_out), 0);
      check("areset_strobe", int'(period_strobe_out), 0);
      check("areset_csync", int'(csync_out), 0);
      vsync = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 20; i <= 22; i++) run_row(i);

      check("no_consecutive_pulses", consec_err, 0);
      check("csync_latency", csync_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
